// File: rtl/mult_pkg.sv
// Shared types and widths for the multiplier job dispatcher slice.
package mult_pkg;

    localparam int unsigned L_WORD_DEFAULT = 4;

    // Dispatcher FSM encoding
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_GUARD = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    // Product width for a given operand width
    function automatic int unsigned prod_w(input int unsigned l_word);
        return 2 * l_word;
    endfunction

endpackage

// File: rtl/mult_job_dispatcher_if.sv
// Operand intake, product output and multiplier-core signals of the dispatcher.
// master: the dispatcher; slave: producer/consumer/multiplier side.
interface mult_job_dispatcher_if import mult_pkg::*; #(
    parameter int unsigned L_word = L_WORD_DEFAULT
);
    localparam int unsigned P_W = prod_w(L_word);

    logic              in_valid;
    logic              in_ready;
    logic [L_word-1:0] in_word1;
    logic [L_word-1:0] in_word2;
    logic              out_valid;
    logic              out_ready;
    logic [P_W-1:0]    out_product;
    logic [L_word-1:0] mul_word1;
    logic [L_word-1:0] mul_word2;
    logic              mul_Start;
    logic              mul_Ready;
    logic [P_W-1:0]    mul_product;

    modport master (
        input  in_valid, in_word1, in_word2, out_ready, mul_Ready, mul_product,
        output in_ready, out_valid, out_product, mul_word1, mul_word2, mul_Start
    );

    modport slave (
        output in_valid, in_word1, in_word2, out_ready, mul_Ready, mul_product,
        input  in_ready, out_valid, out_product, mul_word1, mul_word2, mul_Start
    );

endinterface

// File: rtl/mult_operand_fifo.sv
// Synchronous operand-pair FIFO; DEPTH must be a power of two, at least 2.
module mult_operand_fifo #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage write; contents need no reset since count gates every read
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push_ok && !pop_ok) begin
                count <= count + CW'(1);
            end else if (pop_ok && !push_ok) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/mult_job_dispatcher.sv
// Buffers operand pairs and runs them one at a time through the shift-add
// multiplier, holding each product for a valid/ready consumer.
// Optional: MULT_ZERO_BYPASS_EN completes zero-operand jobs in S_IDLE without
// starting the multiplier.
module mult_job_dispatcher import mult_pkg::*; #(
    parameter int unsigned L_word     = L_WORD_DEFAULT,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              clock,
    input  logic              reset,
    mult_job_dispatcher_if.master bus,
    output logic              busy,
    output logic [CNT_W-1:0]  done_count
);
    localparam int unsigned P_W = prod_w(L_word);

    state_t            state;
    state_t            state_nx;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic [P_W-1:0]    head;
    logic [L_word-1:0] head_w1;
    logic [L_word-1:0] head_w2;
    logic              head_zero_c;
    logic              dispatch_c;
    logic              bypass_c;
    logic              complete_c;

    assign bus.in_ready = !fifo_full;
    assign push         = bus.in_valid && !fifo_full;
    assign pop          = dispatch_c || bypass_c;
    assign head_w1      = head[P_W-1:L_word];
    assign head_w2      = head[L_word-1:0];
    assign bus.mul_Start = (state == S_ISSUE);
    assign busy         = (state != S_IDLE);

`ifdef MULT_ZERO_BYPASS_EN
    assign head_zero_c = (head_w1 == '0) || (head_w2 == '0);
`else
    assign head_zero_c = 1'b0;
`endif

    mult_operand_fifo #(
        .W     (P_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata ({bus.in_word1, bus.in_word2}),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and dispatch/completion strobes
    always_comb begin
        state_nx   = state;
        dispatch_c = 1'b0;
        bypass_c   = 1'b0;
        complete_c = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty && !bus.out_valid && bus.mul_Ready) begin
                    if (head_zero_c) begin
                        bypass_c = 1'b1;
                    end else begin
                        dispatch_c = 1'b1;
                        state_nx   = S_ISSUE;
                    end
                end
            end
            S_ISSUE: state_nx = S_GUARD;
            // Multiplier drops Ready on the edge after Start; skip that cycle
            S_GUARD: state_nx = S_WAIT;
            S_WAIT: begin
                if (bus.mul_Ready) begin
                    complete_c = 1'b1;
                    state_nx   = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Operand words stay put until the next dispatch; the core's empty detect reads them live
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus.mul_word1 <= '0;
            bus.mul_word2 <= '0;
        end else if (dispatch_c) begin
            bus.mul_word1 <= head_w1;
            bus.mul_word2 <= head_w2;
        end
    end

    // Held product register and completed-job counter
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus.out_valid   <= 1'b0;
            bus.out_product <= '0;
            done_count      <= '0;
        end else begin
            if (complete_c) begin
                bus.out_valid   <= 1'b1;
                bus.out_product <= bus.mul_product;
            end else if (bypass_c) begin
                bus.out_valid   <= 1'b1;
                bus.out_product <= '0;
            end else if (bus.out_valid && bus.out_ready) begin
                bus.out_valid   <= 1'b0;
            end
            if (complete_c || bypass_c) begin
                done_count <= done_count + CNT_W'(1);
            end
        end
    end

endmodule
